nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_serial_adder_ctrl.sv | 86 ++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add/sub done over N=WIDTH/4 cycles on one 4-bit CLA cell, LSB nibble first.
module ic_7483 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c0,
  output logic [3:0] o_s,
  output logic       o_c4
);
  logic [3:0] w_g, w_p, w_c;
  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;
  assign w_c[0] = i_c0;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c0);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c0);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]) | (w_p[2] & w_p[1] & w_p[0] & i_c0);
  assign o_c4 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1]) | (w_p[3] & w_p[2] & w_p[1] & w_g[0]) | (&w_p & i_c0);
  assign o_s = w_p ^ w_c;
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / 4;
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_opa, r_opb, r_sum;
  logic             r_carry, r_cout, r_ovf;
  logic [3:0]       w_na, w_nb, w_s;
  logic             w_c4;
  assign w_na = r_opa[4*r_idx +: 4];
  assign w_nb = r_opb[4*r_idx +: 4];
  ic_7483 u_add (.i_a(w_na), .i_b(w_nb), .i_c0(r_carry), .o_s(w_s), .o_c4(w_c4));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == RUN) begin
      r_sum[4*r_idx +: 4] <= w_s;
      r_carry <= w_c4;
      r_idx   <= r_idx + IW'(1);
      if (r_idx == IW'(N - 1)) begin
        r_cout  <= w_c4;
        // carry into the MSB is recovered from the MSB sum bit and its operands
        r_ovf   <= r_opa[WIDTH-1] ^ r_opb[WIDTH-1] ^ w_s[3] ^ w_c4;
        r_state <= DONE;
      end
    end else if (start) begin
      r_opa   <= a;
      r_opb   <= sub ? ~b : b;
      r_carry <= sub | cin;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
      r_state <= RUN;
    end else begin
      r_state <= IDLE;
    end
  end
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed scoreboard bench for the nibble-serial adder, WIDTH=16.
module tb_nibble_serial_adder_ctrl;
  localparam int W = 16;
  localparam int N = W / 4;
  typedef struct packed {logic [W-1:0] s; logic c; logic v;} exp_t;
  logic clk = 0, rst = 0, start = 0, cin = 0, sub = 0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, cout, ovf;
  logic [W-1:0] sum;
  exp_t q[$];
  exp_t last;
  int n_cmp = 0, n_err = 0;
  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic s);
    logic [W-1:0] yy;
    logic [W:0] f;
    exp_t e;
    yy = s ? ~y : y;
    f = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s | ci};
    e.s = f[W-1:0];
    e.c = f[W];
    e.v = (x[W-1] == yy[W-1]) && (f[W-1] != x[W-1]);
    return e;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(logic st, logic [W-1:0] x, logic [W-1:0] y, logic ci, logic s, logic push);
    start = st; a = x; b = y; cin = ci; sub = s;
    if (push) q.push_back(model(x, y, ci, s));
  endtask
  task automatic pop_chk(string tag);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      last = q.pop_front();
      chk({tag, "_sum"}, {16'd0, sum}, {16'd0, last.s});
      chk({tag, "_cout"}, {31'd0, cout}, {31'd0, last.c});
      chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, last.v});
    end
  endtask
  task automatic run_op(string tag, logic [W-1:0] x, logic [W-1:0] y, logic ci, logic s);
    @(negedge clk); drive(1, x, y, ci, s, 1);
    @(negedge clk); drive(0, $urandom, $urandom, 0, 0, 0);
    chk({tag, "_busy_e0"}, {30'd0, busy, done}, 32'b10);
    repeat (N - 1) @(negedge clk);
    chk({tag, "_busy_last"}, {30'd0, busy, done}, 32'b10);
    @(negedge clk);
    pop_chk(tag);
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'b00);
    chk({tag, "_hold"}, {15'd0, sum, cout}, {15'd0, last.s, last.c});
  endtask
  initial begin
    #1 rst = 1;
    @(negedge clk);
    chk("reset_outs", {12'd0, busy, done, sum, cout, ovf}, 32'd0);
    rst = 0;
    run_op("add_basic", 16'h1234, 16'h4321, 0, 0);
    run_op("ripple", 16'hFFFF, 16'h0001, 0, 0);
    run_op("ovf_cin", 16'h7FFF, 16'h0000, 1, 0);
    run_op("sub_neg", 16'h0005, 16'h0007, 1, 1);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1, 1);
    // start during RUN must be ignored
    @(negedge clk); drive(1, 16'h0001, 16'h0001, 0, 0, 1);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 16'hAAAA, 16'h5555, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    chk("rej_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    pop_chk("reject");
    @(negedge clk);
    chk("rej_no_second", {30'd0, busy, done}, 32'b00);
    @(negedge clk);
    chk("rej_still_idle", {30'd0, busy, done}, 32'b00);
    // start held high: accepts at E0 and E5
    @(negedge clk); drive(1, $urandom, $urandom, $urandom, $urandom, 1);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 4 || k == 9) pop_chk("b2b");
      else if (k == 10) chk("b2b_end", {30'd0, busy, done}, 32'b00);
      else chk("b2b_busy", {30'd0, busy, done}, 32'b10);
      drive(k + 1 < 10, $urandom, $urandom, $urandom, $urandom, k + 1 == 5);
    end
    // asynchronous reset in the middle of an operation
    @(negedge clk); drive(1, 16'hFFFF, 16'hFFFF, 1, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1;
    #1 chk("rst_async", {12'd0, busy, done, sum, cout, ovf}, 32'd0);
    @(negedge clk);
    chk("rst_held", {12'd0, busy, done, sum, cout, ovf}, 32'd0);
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", {30'd0, busy, done}, 32'b00);
    end
    run_op("after_rst", 16'h0F0F, 16'h00F1, 0, 0);
    chk("sb_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
